// File: rtl/ctrl_unit_if.sv
// Control-unit <-> datapath connection bundle.
// The master side (control unit) reads the IR fields and status and drives
// the ALU op code and every datapath strobe; the slave side is the datapath.
interface ctrl_unit_if;
  logic       en;
  logic [4:0] opcode;
  logic [2:0] s;
  logic [7:0] status;
  logic [1:0] op;
  logic       ipc;
  logic       clpc;
  logic       wpc;
  logic       wir;
  logic       wreg;
  logic       inm;
  logic       wmem;
  logic       rmem;
  logic       wmar;
  logic       wsreg;
  logic       halted;
  logic       illegal;

  modport master (
    input  en, opcode, s, status,
    output op, ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg,
    output halted, illegal
  );

  modport slave (
    output en, opcode, s, status,
    input  op, ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg,
    input  halted, illegal
  );
endinterface

// File: rtl/ctrl_unit.sv
// YASAC multi-cycle control unit: INIT -> FETCH -> EX1 [-> EX2] -> FETCH.
// Only the state and the sticky illegal flag are registered; every strobe is
// decoded combinationally from state, opcode, branch selector and status.
module ctrl_unit #(
  parameter logic [1:0] ALU_PASSA = 2'b10,
  parameter logic [1:0] ALU_PASSB = 2'b11
) (
  input  logic          clk,
  input  logic          rst_n,
  ctrl_unit_if.master   bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EX1   = 3'd2,
    S_EX2   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Opcode classes shared by next-state and output decode
  logic is_nop, is_halt, is_alu_r, is_alu_k;
  logic is_ld, is_st, is_mem, is_mem_k;
  logic is_jmp, is_br, is_brn, is_undef, br_bit;

  always_comb begin
    is_nop   = (bus.opcode == 5'b00000);
    is_halt  = (bus.opcode == 5'b00001);
    is_alu_r = (bus.opcode[4:2] == 3'b010);
    is_alu_k = (bus.opcode[4:2] == 3'b011);
    is_ld    = (bus.opcode == 5'b10000) || (bus.opcode == 5'b10001);
    is_st    = (bus.opcode == 5'b10010) || (bus.opcode == 5'b10011);
    is_mem   = is_ld || is_st;
    // Immediate-address forms: LD ra,(k) and ST (k),ra
    is_mem_k = (bus.opcode == 5'b10001) || (bus.opcode == 5'b10010);
    is_jmp   = (bus.opcode == 5'b11000);
    is_br    = (bus.opcode == 5'b11001);
    is_brn   = (bus.opcode == 5'b11010);
    br_bit   = bus.status[bus.s];
    is_undef = !(is_nop || is_halt || is_alu_r || is_alu_k || is_mem ||
                 is_jmp || is_br || is_brn);
  end

  // State register and sticky illegal flag, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state decode; en=0 freezes both the state and the illegal flag
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (bus.en) begin
      case (state_q)
        S_INIT:  state_d = S_FETCH;
        S_FETCH: state_d = S_EX1;
        S_EX1: begin
          if (is_halt)     state_d = S_HALT;
          else if (is_mem) state_d = S_EX2;
          else             state_d = S_FETCH;
          if (is_undef) illegal_d = 1'b1;
        end
        S_EX2:   state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Strobe decode; everything defaults low and en=0 keeps it that way
  always_comb begin
    bus.op    = 2'b00;
    bus.ipc   = 1'b0;
    bus.clpc  = 1'b0;
    bus.wpc   = 1'b0;
    bus.wir   = 1'b0;
    bus.wreg  = 1'b0;
    bus.inm   = 1'b0;
    bus.wmem  = 1'b0;
    bus.rmem  = 1'b0;
    bus.wmar  = 1'b0;
    bus.wsreg = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_INIT:  bus.clpc = 1'b1;
        S_FETCH: begin
          bus.wir = 1'b1;
          bus.ipc = 1'b1;
        end
        S_EX1: begin
          if (is_alu_r || is_alu_k) begin
            bus.op    = bus.opcode[1:0];
            bus.inm   = is_alu_k;
            bus.wreg  = 1'b1;
            bus.wsreg = 1'b1;
          end else if (is_mem) begin
            // Address goes through the ALU's pass-b path into MAR
            bus.op   = ALU_PASSB;
            bus.inm  = is_mem_k;
            bus.wmar = 1'b1;
          end else if (is_jmp || (is_br && br_bit) || (is_brn && !br_bit)) begin
            // Absolute target k passed straight to the PC
            bus.op  = ALU_PASSB;
            bus.inm = 1'b1;
            bus.wpc = 1'b1;
          end
        end
        S_EX2: begin
          if (is_ld) begin
            bus.rmem = 1'b1;
            bus.wreg = 1'b1;
          end else if (is_st) begin
            bus.op   = ALU_PASSA;
            bus.wmem = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs: halted follows the state regardless of en
  always_comb begin
    bus.halted  = (state_q == S_HALT);
    bus.illegal = illegal_q;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Multi-cycle control unit for the YASAC datapath.
- Sequences fetch/execute by driving every datapath strobe (op, ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg) from the current opcode, branch selector s and status register.
- Sits beside the data unit in the top-level computer; one instruction takes 2 or 3 cycles.

Parameters:
ALU_PASSA, 2'b10, ALU op code whose result equals input a (used for stores)
ALU_PASSB, 2'b11, ALU op code whose result equals input b (used for addresses, jumps)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; 0 stalls the FSM and forces all strobes to 0
opcode  input  5  opcode of instruction in IR
s  input  3  status bit selector from IR
status  input  8  status register contents (---SVNZC)
op  output  2  ALU operation code
ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg  output  1 each  datapath strobes
halted  output  1  1 while in HALT state
illegal  output  1  sticky flag: an undefined opcode was executed

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. While rst_n=0: state=INIT, illegal=0.
- States: INIT, FETCH, EX1, EX2, HALT. State register and illegal are the only flops; strobes are combinational from state, opcode, s, status and en.
- Default strobe value: every strobe not listed for a state/opcode is 0. op defaults to 2'b00.
- en gating: en=0 forces all strobes to 0 and holds state; this applies in every state, including INIT. halted still reflects the state.
- INIT: clpc=1 (including during reset); -> FETCH.
- FETCH: wir=1, ipc=1; -> EX1.
- EX1 decode by opcode:
  - 00000 NOP: no strobes; -> FETCH.
  - 00001 HALT: -> HALT.
  - 010oo ALU ra<=ra op rb: op=oo, inm=0, wreg=1, wsreg=1; -> FETCH.
  - 011oo ALU ra<=ra op k: op=oo, inm=1, wreg=1, wsreg=1; -> FETCH.
  - 10000 LD ra,(rb) and 10011 ST (rb),ra: op=ALU_PASSB, inm=0, wmar=1; -> EX2.
  - 10001 LD ra,(k) and 10010 ST (k),ra: op=ALU_PASSB, inm=1, wmar=1; -> EX2.
  - 11000 JMP k: op=ALU_PASSB, inm=1, wpc=1; -> FETCH.
  - 11001 BR s,k: if status[s]=1, same strobes as JMP, else none; -> FETCH.
  - 11010 BRN s,k: if status[s]=0, same strobes as JMP, else none; -> FETCH.
  - any other opcode: executes as NOP; illegal<=1; -> FETCH.
- EX2:
  - LD (10000/10001): rmem=1, wreg=1.
  - ST (10010/10011): op=ALU_PASSA, inm=0, wmem=1.
  - -> FETCH.
- HALT: no strobes, halted=1; remains until rst_n=0.
- Branch targets are absolute (pc<=k). PC already points to the next instruction after FETCH.
- Timing: wsreg is never asserted by LD, ST, JMP or branches. ipc and wpc are never asserted in the same cycle. wir is asserted only in FETCH.
- Reset mid-instruction: reset aborts immediately; the next state after release is INIT, then FETCH.
- illegal clears only on reset.

Test Plan:
1. Reset: rst_n=0 -> clpc=1, all other strobes 0, halted=0; release with en=1 -> INIT, then FETCH with wir=1, ipc=1.
2. ALU register op, opcode=01001 -> EX1: op=01, inm=0, wreg=1, wsreg=1, wmar=0; next cycle FETCH. Repeat with 01110 -> op=10, inm=1.
3. Load/store, opcode=10001 -> EX1: op=11, inm=1, wmar=1; EX2: rmem=1, wreg=1, wsreg=0. Opcode=10011 -> EX1: inm=0, wmar=1; EX2: op=10, wmem=1.
4. Branches, opcode=11001, s=3: status=8'h08 -> wpc=1, op=11, inm=1; status=8'h00 -> no strobes. Opcode 11010 with same status values gives the inverse result.
5. HALT/illegal: opcode=00001 -> halted=1 from the next cycle, no wir for 10 cycles. Separately, opcode=11111 -> illegal=1 persists across the following instructions, no write strobes. rst_n pulse clears both.
6. Stall: en=0 for 3 cycles during EX2 of ST -> all strobes 0, state held; en=1 -> wmem=1 exactly once, then FETCH.
